// File: rtl/axil_mux_pkg.sv
// Shared types and the round-robin winner function for the AXI-lite requester mux.
package axil_mux_pkg;

   // Grant indices are sized for the largest supported port count.
   localparam int MAX_PORTS = 16;
   localparam int IDX_W     = 4;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_RESP = 2'd2
   } rd_state_t;

   // Returns the first requesting index after 'last', wrapping modulo n.
   // With no request at all the result is 0; callers only use it when |req.
   function automatic logic [IDX_W-1:0] rr_next(
      input logic [MAX_PORTS-1:0] req,
      input logic [IDX_W-1:0]     last,
      input int                   n
   );
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] idx4;
      logic             found;
      int               idx;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= MAX_PORTS; i++) begin
         idx  = (int'(last) + i) % n;
         idx4 = idx[IDX_W-1:0];
         if (!found && (i <= n) && req[idx4]) begin
            win   = idx4;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/axil_rr_arb.sv
// Round-robin arbiter holding a registered grant until the owner releases it.
module axil_rr_arb
   import axil_mux_pkg::*;
#(
   parameter int S_COUNT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [S_COUNT-1:0] req,
   input  logic               req_en,
   input  logic               grant_release,
   output logic [IDX_W-1:0]   grant,
   output logic               grant_valid
);

   logic [IDX_W-1:0]     grant_reg;
   logic                 grant_valid_reg;
   logic [IDX_W-1:0]     last_reg;
   logic [MAX_PORTS-1:0] req_wide;

   // Zero-extend the request vector to the width the package function expects.
   always_comb begin
      req_wide               = '0;
      req_wide[S_COUNT-1:0] = req;
   end

   // Grant register: capture a winner when idle, remember it as 'last' on release.
   // 'last' starts at the top port so port 0 is the first winner after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_reg       <= '0;
         grant_valid_reg <= 1'b0;
         last_reg        <= IDX_W'(S_COUNT - 1);
      end else if (grant_release) begin
         grant_valid_reg <= 1'b0;
         last_reg        <= grant_reg;
      end else if (req_en && !grant_valid_reg && (|req)) begin
         grant_reg       <= rr_next(req_wide, last_reg, S_COUNT);
         grant_valid_reg <= 1'b1;
      end
   end

   assign grant       = grant_reg;
   assign grant_valid = grant_valid_reg;

endmodule

// File: rtl/axil_rr_mux.sv
// Shares one AXI-lite master port between S_COUNT requesters, with independent
// round-robin arbitration and one outstanding transaction per direction.
module axil_rr_mux
   import axil_mux_pkg::*;
#(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [S_COUNT*3-1:0]          s_axil_awprot,
   input  logic [S_COUNT-1:0]            s_axil_awvalid,
   output logic [S_COUNT-1:0]            s_axil_awready,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [S_COUNT*STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic [S_COUNT-1:0]            s_axil_wvalid,
   output logic [S_COUNT-1:0]            s_axil_wready,
   output logic [S_COUNT*2-1:0]          s_axil_bresp,
   output logic [S_COUNT-1:0]            s_axil_bvalid,
   input  logic [S_COUNT-1:0]            s_axil_bready,
   input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [S_COUNT*3-1:0]          s_axil_arprot,
   input  logic [S_COUNT-1:0]            s_axil_arvalid,
   output logic [S_COUNT-1:0]            s_axil_arready,
   output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
   output logic [S_COUNT*2-1:0]          s_axil_rresp,
   output logic [S_COUNT-1:0]            s_axil_rvalid,
   input  logic [S_COUNT-1:0]            s_axil_rready,
   output logic [ADDR_WIDTH-1:0]         m_axil_awaddr,
   output logic [2:0]                    m_axil_awprot,
   output logic                          m_axil_awvalid,
   input  logic                          m_axil_awready,
   output logic [DATA_WIDTH-1:0]         m_axil_wdata,
   output logic [STRB_WIDTH-1:0]         m_axil_wstrb,
   output logic                          m_axil_wvalid,
   input  logic                          m_axil_wready,
   input  logic [1:0]                    m_axil_bresp,
   input  logic                          m_axil_bvalid,
   output logic                          m_axil_bready,
   output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
   output logic [2:0]                    m_axil_arprot,
   output logic                          m_axil_arvalid,
   input  logic                          m_axil_arready,
   input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
   input  logic [1:0]                    m_axil_rresp,
   input  logic                          m_axil_rvalid,
   output logic                          m_axil_rready,
   output logic                          wr_busy,
   output logic                          rd_busy
);

   logic [1:0]       rst_sync_reg;
   logic             rst_int_n;

   wr_state_t        wr_state_reg, wr_state_next;
   rd_state_t        rd_state_reg, rd_state_next;
   logic             aw_done_reg, aw_done_next;
   logic             w_done_reg, w_done_next;
   logic             wr_release, rd_release;

   logic [IDX_W-1:0] wr_grant, rd_grant;
   logic             wr_grant_valid, rd_grant_valid;
   logic [S_COUNT-1:0] wr_sel, rd_sel;

   logic             wr_addr_ph, wr_resp_ph, rd_addr_ph, rd_resp_ph;
   logic             aw_hs, w_hs, ar_hs;

   logic [ADDR_WIDTH-1:0] awaddr_mux, araddr_mux;
   logic [2:0]            awprot_mux, arprot_mux;
   logic [DATA_WIDTH-1:0] wdata_mux;
   logic [STRB_WIDTH-1:0] wstrb_mux;

   // Reset asserts immediately; its removal is delayed through two flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_reg <= 2'b00;
      end else begin
         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_reg[1];

   axil_rr_arb #(.S_COUNT(S_COUNT)) u_wr_arb (
      .clk           (clk),
      .rst_n         (rst_int_n),
      .req           (s_axil_awvalid),
      .req_en        (wr_state_reg == W_IDLE),
      .grant_release (wr_release),
      .grant         (wr_grant),
      .grant_valid   (wr_grant_valid)
   );

   axil_rr_arb #(.S_COUNT(S_COUNT)) u_rd_arb (
      .clk           (clk),
      .rst_n         (rst_int_n),
      .req           (s_axil_arvalid),
      .req_en        (rd_state_reg == R_IDLE),
      .grant_release (rd_release),
      .grant         (rd_grant),
      .grant_valid   (rd_grant_valid)
   );

   assign wr_addr_ph = (wr_state_reg == W_ADDR) & wr_grant_valid;
   assign wr_resp_ph = (wr_state_reg == W_RESP) & wr_grant_valid;
   assign rd_addr_ph = (rd_state_reg == R_ADDR) & rd_grant_valid;
   assign rd_resp_ph = (rd_state_reg == R_RESP) & rd_grant_valid;

   // One-hot port selects and per-port demux of ready/valid; responses are replicated.
   generate
      for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
         assign wr_sel[gi]         = (wr_grant == IDX_W'(gi));
         assign rd_sel[gi]         = (rd_grant == IDX_W'(gi));
         assign s_axil_awready[gi] = wr_addr_ph & wr_sel[gi] & m_axil_awready & ~aw_done_reg;
         assign s_axil_wready[gi]  = wr_addr_ph & wr_sel[gi] & m_axil_wready & ~w_done_reg;
         assign s_axil_bvalid[gi]  = wr_resp_ph & wr_sel[gi] & m_axil_bvalid;
         assign s_axil_arready[gi] = rd_addr_ph & rd_sel[gi] & m_axil_arready;
         assign s_axil_rvalid[gi]  = rd_resp_ph & rd_sel[gi] & m_axil_rvalid;
         assign s_axil_bresp[gi*2 +: 2]                   = m_axil_bresp;
         assign s_axil_rresp[gi*2 +: 2]                   = m_axil_rresp;
         assign s_axil_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
      end
   endgenerate

   // Payload selection from the granted port of each direction.
   always_comb begin
      awaddr_mux = '0;
      awprot_mux = '0;
      wdata_mux  = '0;
      wstrb_mux  = '0;
      araddr_mux = '0;
      arprot_mux = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (wr_sel[i]) begin
            awaddr_mux = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            awprot_mux = s_axil_awprot[i*3 +: 3];
            wdata_mux  = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wstrb_mux  = s_axil_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
         end
         if (rd_sel[i]) begin
            araddr_mux = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            arprot_mux = s_axil_arprot[i*3 +: 3];
         end
      end
   end

   // Master-side outputs; payload is forced to zero outside the address phase.
   always_comb begin
      m_axil_awaddr  = wr_addr_ph ? awaddr_mux : '0;
      m_axil_awprot  = wr_addr_ph ? awprot_mux : '0;
      m_axil_wdata   = wr_addr_ph ? wdata_mux  : '0;
      m_axil_wstrb   = wr_addr_ph ? wstrb_mux  : '0;
      m_axil_awvalid = wr_addr_ph & (|(s_axil_awvalid & wr_sel)) & ~aw_done_reg;
      m_axil_wvalid  = wr_addr_ph & (|(s_axil_wvalid & wr_sel)) & ~w_done_reg;
      m_axil_bready  = wr_resp_ph & (|(s_axil_bready & wr_sel));
      m_axil_araddr  = rd_addr_ph ? araddr_mux : '0;
      m_axil_arprot  = rd_addr_ph ? arprot_mux : '0;
      m_axil_arvalid = rd_addr_ph & (|(s_axil_arvalid & rd_sel));
      m_axil_rready  = rd_resp_ph & (|(s_axil_rready & rd_sel));
   end

   assign aw_hs   = m_axil_awvalid & m_axil_awready;
   assign w_hs    = m_axil_wvalid & m_axil_wready;
   assign ar_hs   = m_axil_arvalid & m_axil_arready;
   assign wr_busy = (wr_state_reg != W_IDLE);
   assign rd_busy = (rd_state_reg != R_IDLE);

   // Write and read FSM state plus the AW/W completion flags.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wr_state_reg <= W_IDLE;
         rd_state_reg <= R_IDLE;
         aw_done_reg  <= 1'b0;
         w_done_reg   <= 1'b0;
      end else begin
         wr_state_reg <= wr_state_next;
         rd_state_reg <= rd_state_next;
         aw_done_reg  <= aw_done_next;
         w_done_reg   <= w_done_next;
      end
   end

   // Write next-state: AW and W may finish in either order before the response.
   always_comb begin
      wr_state_next = wr_state_reg;
      aw_done_next  = aw_done_reg;
      w_done_next   = w_done_reg;
      wr_release    = 1'b0;
      case (wr_state_reg)
         W_IDLE: begin
            if (|s_axil_awvalid) wr_state_next = W_ADDR;
         end
         W_ADDR: begin
            if (aw_hs) aw_done_next = 1'b1;
            if (w_hs)  w_done_next  = 1'b1;
            if (aw_done_next && w_done_next) begin
               wr_state_next = W_RESP;
               aw_done_next  = 1'b0;
               w_done_next   = 1'b0;
            end
         end
         W_RESP: begin
            if (m_axil_bvalid && m_axil_bready) begin
               wr_state_next = W_IDLE;
               wr_release    = 1'b1;
            end
         end
         default: wr_state_next = W_IDLE;
      endcase
   end

   // Read next-state: address handshake, then the data response.
   always_comb begin
      rd_state_next = rd_state_reg;
      rd_release    = 1'b0;
      case (rd_state_reg)
         R_IDLE: begin
            if (|s_axil_arvalid) rd_state_next = R_ADDR;
         end
         R_ADDR: begin
            if (ar_hs) rd_state_next = R_RESP;
         end
         R_RESP: begin
            if (m_axil_rvalid && m_axil_rready) begin
               rd_state_next = R_IDLE;
               rd_release    = 1'b1;
            end
         end
         default: rd_state_next = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axil_rr_mux.sv
// Directed bench for the AXI-lite round-robin requester mux.
module tb_axil_rr_mux;

   localparam int S  = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [S*AW-1:0] s_axil_awaddr, s_axil_araddr;
   logic [S*3-1:0]  s_axil_awprot, s_axil_arprot;
   logic [S-1:0]    s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
   logic [S*DW-1:0] s_axil_wdata, s_axil_rdata;
   logic [S*SW-1:0] s_axil_wstrb;
   logic [S*2-1:0]  s_axil_bresp, s_axil_rresp;
   logic [S-1:0]    s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
   logic [S-1:0]    s_axil_rvalid, s_axil_rready;
   logic [AW-1:0]   m_axil_awaddr, m_axil_araddr;
   logic [2:0]      m_axil_awprot, m_axil_arprot;
   logic            m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [DW-1:0]   m_axil_wdata, m_axil_rdata;
   logic [SW-1:0]   m_axil_wstrb;
   logic [1:0]      m_axil_bresp, m_axil_rresp;
   logic            m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
   logic            m_axil_rvalid, m_axil_rready;
   logic            wr_busy, rd_busy;

   int total = 0;
   int bad   = 0;

   axil_rr_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
      .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
      .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
      .wr_busy(wr_busy), .rd_busy(rd_busy)
   );

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   function automatic int oh_idx(input logic [S-1:0] v);
      int r = -1;
      int c = 0;
      for (int i = 0; i < S; i++) begin
         if (v[i]) begin
            r = i;
            c++;
         end
      end
      return (c == 1) ? r : -1;
   endfunction

   task automatic clear_inputs;
      s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = '0;
      s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = '0; s_axil_bready = '0;
      s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = '0; s_axil_rready = '0;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = '0; m_axil_bvalid = 1'b0;
      m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;
   endtask

   // Master-side slave model for one write: accepts AW+W together, returns B.
   task automatic wr_cycle(output int aport, output int wport, output int bport, output bit to);
      int n = 0;
      aport = -1; wport = -1; bport = -1; to = 1'b0;
      #1;
      while (!m_axil_awvalid && n < 10) begin
         tick;
         n++;
      end
      if (!m_axil_awvalid) begin
         to = 1'b1;
         return;
      end
      m_axil_awready = 1'b1; m_axil_wready = 1'b1; #1;
      aport = oh_idx(s_axil_awready);
      wport = oh_idx(s_axil_wready);
      tick;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b1; #1;
      bport = oh_idx(s_axil_bvalid);
      tick;
      m_axil_bvalid = 1'b0;
   endtask

   // Master-side slave model for one read.
   task automatic rd_cycle(output int aport, output int rport, output bit to);
      int n = 0;
      aport = -1; rport = -1; to = 1'b0;
      #1;
      while (!m_axil_arvalid && n < 10) begin
         tick;
         n++;
      end
      if (!m_axil_arvalid) begin
         to = 1'b1;
         return;
      end
      m_axil_arready = 1'b1; #1;
      aport = oh_idx(s_axil_arready);
      tick;
      m_axil_arready = 1'b0; m_axil_rvalid = 1'b1; #1;
      rport = oh_idx(s_axil_rvalid);
      tick;
      m_axil_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst_n = 1'b0;
      tick; tick;
      s_axil_awvalid = '1; s_axil_wvalid = '1; s_axil_arvalid = '1; s_axil_bready = '1;
      m_axil_awready = 1'b1; m_axil_arready = 1'b1;
      tick; #1;
      total++;
      if (wr_busy !== 1'b0 || rd_busy !== 1'b0 || m_axil_awvalid !== 1'b0 || m_axil_arvalid !== 1'b0 ||
          s_axil_awready !== '0 || s_axil_arready !== '0 || m_axil_awaddr !== '0) begin
         bad++;
         $display("FAIL reset_hold: busy=%b%b awv=%b arv=%b awr=%b arr=%b required all zero",
                  wr_busy, rd_busy, m_axil_awvalid, m_axil_arvalid, s_axil_awready, s_axil_arready);
      end
      clear_inputs();
      rst_n = 1'b1;
      tick; tick; tick;
      total++;
      if (wr_busy !== 1'b0 || rd_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: wr_busy=%b rd_busy=%b required 0 0", wr_busy, rd_busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_write;
      s_axil_awaddr[1*AW +: AW] = 32'h10;
      s_axil_awprot[1*3 +: 3]   = 3'b010;
      s_axil_wdata[1*DW +: DW]  = 32'hA5A5A5A5;
      s_axil_wstrb[1*SW +: SW]  = 4'hF;
      s_axil_awvalid[1] = 1'b1; s_axil_wvalid[1] = 1'b1; s_axil_bready = 4'b0010;
      #1;
      total++;
      if (m_axil_awvalid !== 1'b0 || m_axil_awaddr !== '0 || wr_busy !== 1'b0) begin
         bad++;
         $display("FAIL write_idle: awvalid=%b awaddr=%h busy=%b required 0 0 0",
                  m_axil_awvalid, m_axil_awaddr, wr_busy);
      end
      tick;
      total++;
      if (m_axil_awvalid !== 1'b1 || m_axil_wvalid !== 1'b1 || m_axil_awaddr !== 32'h10 ||
          m_axil_awprot !== 3'b010 || m_axil_wdata !== 32'hA5A5A5A5 || m_axil_wstrb !== 4'hF) begin
         bad++;
         $display("FAIL write_payload: v=%b%b addr=%h prot=%b data=%h strb=%h required 11 10 010 a5a5a5a5 f",
                  m_axil_awvalid, m_axil_wvalid, m_axil_awaddr, m_axil_awprot, m_axil_wdata, m_axil_wstrb);
      end
      m_axil_awready = 1'b1; m_axil_wready = 1'b1; #1;
      total++;
      if (s_axil_awready !== 4'b0010 || s_axil_wready !== 4'b0010) begin
         bad++;
         $display("FAIL write_ready: awready=%b wready=%b required 0010 0010", s_axil_awready, s_axil_wready);
      end
      tick;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0;
      s_axil_awvalid = '0; s_axil_wvalid = '0;
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10; #1;
      total++;
      if (s_axil_bvalid !== 4'b0010 || s_axil_bresp[1*2 +: 2] !== 2'b10 || m_axil_bready !== 1'b1) begin
         bad++;
         $display("FAIL write_b: bvalid=%b bresp1=%b bready=%b required 0010 10 1",
                  s_axil_bvalid, s_axil_bresp[1*2 +: 2], m_axil_bready);
      end
      tick;
      m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00; #1;
      total++;
      if (wr_busy !== 1'b0 || s_axil_bvalid !== '0) begin
         bad++;
         $display("FAIL write_done: busy=%b bvalid=%b required 0 0000", wr_busy, s_axil_bvalid);
      end
      clear_inputs();
      $display("test_write done");
   endtask

   task automatic test_rr_reads;
      int cnt[S];
      int p, rp;
      bit to;
      for (int i = 0; i < S; i++) cnt[i] = 0;
      s_axil_arvalid = '1; s_axil_rready = '1;
      for (int k = 0; k < 32; k++) begin
         rd_cycle(p, rp, to);
         total++;
         if (to || p != (k % S) || rp != (k % S)) begin
            bad++;
            $display("FAIL rr_read[%0d]: ar port=%0d r port=%0d timeout=%0d required %0d", k, p, rp, to, k % S);
         end else begin
            $display("rr_read[%0d] port %0d", k, p);
         end
         if (p >= 0 && p < S) begin
            cnt[p]++;
            if (cnt[p] == 8) s_axil_arvalid[p] = 1'b0;
         end
      end
      for (int i = 0; i < S; i++) begin
         total++;
         if (cnt[i] != 8) begin
            bad++;
            $display("FAIL rr_count[%0d]: reads=%0d required 8", i, cnt[i]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_w_before_aw;
      bit early = 1'b0;
      s_axil_wvalid[0] = 1'b1; s_axil_wdata[0 +: DW] = 32'h0BADF00D; s_axil_wstrb[0 +: SW] = 4'h3;
      s_axil_bready = '1;
      repeat (3) begin
         tick;
         if (wr_busy !== 1'b0 || m_axil_wvalid !== 1'b0 || s_axil_wready !== '0) early = 1'b1;
      end
      total++;
      if (early) begin
         bad++;
         $display("FAIL wonly_nogrant: write granted with wvalid only, required no grant");
      end
      s_axil_awvalid[0] = 1'b1; s_axil_awaddr[0 +: AW] = 32'h44;
      tick;
      total++;
      if (m_axil_awvalid !== 1'b1 || m_axil_wvalid !== 1'b1 || m_axil_wdata !== 32'h0BADF00D) begin
         bad++;
         $display("FAIL wfirst_fwd: awv=%b wv=%b wdata=%h required 1 1 0badf00d",
                  m_axil_awvalid, m_axil_wvalid, m_axil_wdata);
      end
      m_axil_awready = 1'b1; tick;
      m_axil_awready = 1'b0; s_axil_awvalid[0] = 1'b0; #1;
      total++;
      if (m_axil_awvalid !== 1'b0 || m_axil_wvalid !== 1'b1 || wr_busy !== 1'b1 || s_axil_bvalid !== '0) begin
         bad++;
         $display("FAIL wfirst_awdone: awv=%b wv=%b busy=%b bvalid=%b required 0 1 1 0000",
                  m_axil_awvalid, m_axil_wvalid, wr_busy, s_axil_bvalid);
      end
      m_axil_wready = 1'b1; #1;
      total++;
      if (s_axil_wready !== 4'b0001) begin
         bad++;
         $display("FAIL wfirst_wready: wready=%b required 0001", s_axil_wready);
      end
      tick;
      m_axil_wready = 1'b0; s_axil_wvalid[0] = 1'b0; m_axil_bvalid = 1'b1; #1;
      total++;
      if (s_axil_bvalid !== 4'b0001) begin
         bad++;
         $display("FAIL wfirst_b: bvalid=%b required 0001", s_axil_bvalid);
      end
      tick;
      m_axil_bvalid = 1'b0; #1;
      total++;
      if (wr_busy !== 1'b0) begin
         bad++;
         $display("FAIL wfirst_done: busy=%b required 0", wr_busy);
      end
      clear_inputs();
      $display("test_w_before_aw done");
   endtask

   task automatic test_concurrent;
      s_axil_arvalid[2] = 1'b1; s_axil_araddr[2*AW +: AW] = 32'h200; s_axil_arprot[2*3 +: 3] = 3'b001;
      s_axil_awvalid[3] = 1'b1; s_axil_wvalid[3] = 1'b1; s_axil_awaddr[3*AW +: AW] = 32'h300;
      s_axil_rready = '1; s_axil_bready = '1;
      tick;
      total++;
      if (wr_busy !== 1'b1 || rd_busy !== 1'b1 || m_axil_araddr !== 32'h200 || m_axil_arprot !== 3'b001 ||
          m_axil_awaddr !== 32'h300) begin
         bad++;
         $display("FAIL conc_addr: busy=%b%b araddr=%h arprot=%b awaddr=%h required 11 200 001 300",
                  wr_busy, rd_busy, m_axil_araddr, m_axil_arprot, m_axil_awaddr);
      end
      m_axil_arready = 1'b1; m_axil_awready = 1'b1; m_axil_wready = 1'b1; #1;
      total++;
      if (s_axil_arready !== 4'b0100 || s_axil_awready !== 4'b1000 || s_axil_wready !== 4'b1000) begin
         bad++;
         $display("FAIL conc_ready: arready=%b awready=%b wready=%b required 0100 1000 1000",
                  s_axil_arready, s_axil_awready, s_axil_wready);
      end
      tick;
      m_axil_arready = 1'b0; m_axil_awready = 1'b0; m_axil_wready = 1'b0;
      s_axil_arvalid = '0; s_axil_awvalid = '0; s_axil_wvalid = '0;
      m_axil_rvalid = 1'b1; m_axil_rdata = 32'h12345678; m_axil_rresp = 2'b01; m_axil_bvalid = 1'b1; #1;
      total++;
      if (s_axil_rvalid !== 4'b0100 || s_axil_bvalid !== 4'b1000 || s_axil_rdata[2*DW +: DW] !== 32'h12345678 ||
          s_axil_rdata[0 +: DW] !== 32'h12345678 || s_axil_rresp[2*2 +: 2] !== 2'b01) begin
         bad++;
         $display("FAIL conc_resp: rvalid=%b bvalid=%b rdata2=%h rdata0=%h required 0100 1000 12345678 12345678",
                  s_axil_rvalid, s_axil_bvalid, s_axil_rdata[2*DW +: DW], s_axil_rdata[0 +: DW]);
      end
      tick;
      m_axil_rvalid = 1'b0; m_axil_bvalid = 1'b0; #1;
      total++;
      if (wr_busy !== 1'b0 || rd_busy !== 1'b0) begin
         bad++;
         $display("FAIL conc_done: busy=%b%b required 00", wr_busy, rd_busy);
      end
      clear_inputs();
      $display("test_concurrent done");
   endtask

   task automatic test_b_stall;
      bit stall_bad = 1'b0;
      int a, w, b;
      bit to;
      s_axil_awvalid = 4'b0011; s_axil_wvalid = 4'b0011; s_axil_bready = 4'b0000;
      tick;
      m_axil_awready = 1'b1; m_axil_wready = 1'b1; #1;
      total++;
      if (s_axil_awready !== 4'b0001) begin
         bad++;
         $display("FAIL stall_first: awready=%b required 0001", s_axil_awready);
      end
      tick;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0;
      s_axil_awvalid[0] = 1'b0; s_axil_wvalid[0] = 1'b0; m_axil_bvalid = 1'b1;
      repeat (5) begin
         #1;
         if (s_axil_bvalid !== 4'b0001 || m_axil_bready !== 1'b0 || wr_busy !== 1'b1 || s_axil_awready !== '0)
            stall_bad = 1'b1;
         tick;
      end
      total++;
      if (stall_bad) begin
         bad++;
         $display("FAIL stall_hold: left W_RESP or regranted while bready[0] low");
      end
      s_axil_bready[0] = 1'b1; #1;
      total++;
      if (m_axil_bready !== 1'b1) begin
         bad++;
         $display("FAIL stall_bready: m_bready=%b required 1", m_axil_bready);
      end
      tick;
      m_axil_bvalid = 1'b0; s_axil_bready = '1;
      wr_cycle(a, w, b, to);
      total++;
      if (to || a != 1 || w != 1 || b != 1) begin
         bad++;
         $display("FAIL stall_next: aw=%0d w=%0d b=%0d timeout=%0d required 1 1 1", a, w, b, to);
      end
      clear_inputs();
      $display("test_b_stall done");
   endtask

   task automatic test_reset_mid;
      int a, w, b;
      bit to;
      s_axil_awvalid[0] = 1'b1; s_axil_wvalid[0] = 1'b1; s_axil_bready = '1;
      tick;
      m_axil_awready = 1'b1; m_axil_wready = 1'b1;
      tick;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b1; #1;
      total++;
      if (wr_busy !== 1'b1 || s_axil_bvalid !== 4'b0001) begin
         bad++;
         $display("FAIL rstmid_pre: busy=%b bvalid=%b required 1 0001", wr_busy, s_axil_bvalid);
      end
      rst_n = 1'b0; #1;
      total++;
      if (s_axil_bvalid !== '0 || m_axil_bready !== 1'b0 || m_axil_awvalid !== 1'b0 || m_axil_wvalid !== 1'b0 ||
          s_axil_awready !== '0 || s_axil_wready !== '0 || wr_busy !== 1'b0 || rd_busy !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_clear: bvalid=%b bready=%b busy=%b%b required 0000 0 00",
                  s_axil_bvalid, m_axil_bready, wr_busy, rd_busy);
      end
      m_axil_bvalid = 1'b0;
      s_axil_awvalid = 4'b0101; s_axil_wvalid = 4'b0101;
      tick; tick;
      rst_n = 1'b1;
      wr_cycle(a, w, b, to);
      total++;
      if (to || a != 0 || w != 0 || b != 0) begin
         bad++;
         $display("FAIL rstmid_first: aw=%0d w=%0d b=%0d timeout=%0d required 0 0 0", a, w, b, to);
      end
      clear_inputs();
      $display("test_reset_mid done");
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_write();
      test_rr_reads();
      test_w_before_aw();
      test_concurrent();
      test_b_stall();
      test_reset_mid();
      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
